reg_load_ctrl: RTL and testbench

REG_LOAD_CTRL -- requirements
Module: reg_load_ctrl

---
 rtl/reg_load_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_reg_load_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_load_ctrl.sv
// reg_load_ctrl
// Serial-load controller for a bank of WIDTH DFlop cells. Bits arrive LSB
// first on a valid/ready serial link; each accepted bit is steered into one
// cell by a one-hot load enable while din carries the bit to every cell.
// In IDLE a clr request drives all load enables with din=0 for one cycle.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   -> after the WIDTH data bits a parity bit is accepted in the
//                PAR state. It is compared against the XOR of the data bits,
//                and a mismatch sets the sticky perr flag.
//   undefined -> no PAR state, SHIFT goes straight to DONE, perr is tied to 0.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   arst       in   asynchronous reset, active-high
//   start      in   begin a WIDTH-bit serial load (IDLE only)
//   abort      in   cancel an in-progress load (SHIFT/PAR only)
//   clr        in   one-cycle clear of the whole bank (IDLE only, start wins)
//   ser_in     in   serial data bit, LSB first
//   ser_valid  in   ser_in holds a valid bit
//   ser_ready  out  controller accepts a bit this cycle
//   load       out  [WIDTH] per-cell load enables (combinational)
//   din        out  common data bit to all cells
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse on load completion
//   perr       out  sticky parity-error flag
//   bit_idx    out  [clog2(WIDTH)] index of the next cell to load
module reg_load_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     clr,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  output logic                     ser_ready,
  output logic [WIDTH-1:0]         load,
  output logic                     din,
  output logic                     busy,
  output logic                     done,
  output logic                     perr,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef PARITY_CHECK_EN
    PAR   = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   bit_idx_r, bit_idx_s;
  logic [WIDTH-1:0] load_s;
  logic            din_s;

  // Running parity update for one accepted data bit.
  function automatic logic parity_step(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  // One-hot load enable for the cell addressed by idx.
  function automatic logic [WIDTH-1:0] one_hot(input logic [IW-1:0] idx);
    return WIDTH'(1) << idx;
  endfunction

`ifdef PARITY_CHECK_EN
  logic par_r, par_s;
  logic perr_r, perr_s;
`endif

  // Next-state and output decode for the load FSM.
  always_comb begin
    state_s   = state_r;
    bit_idx_s = bit_idx_r;
    ser_ready = 1'b0;
    load_s    = {WIDTH{1'b0}};
    din_s     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
`ifdef PARITY_CHECK_EN
    par_s     = par_r;
    perr_s    = perr_r;
`endif
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_s   = SHIFT;
          bit_idx_s = {IW{1'b0}};
`ifdef PARITY_CHECK_EN
          par_s     = 1'b0;
          perr_s    = 1'b0;
`endif
        end else if (clr) begin
          // Every cell loads din=0 in this single cycle.
          load_s = {WIDTH{1'b1}};
          din_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        din_s = ser_in;
        if (abort) begin
          // Abort beats a simultaneous valid bit; loaded cells keep values.
          state_s   = IDLE;
          bit_idx_s = {IW{1'b0}};
        end else begin
          ser_ready = 1'b1;
          if (ser_valid) begin
            load_s = one_hot(bit_idx_r);
`ifdef PARITY_CHECK_EN
            par_s  = parity_step(par_r, ser_in);
`endif
            if (bit_idx_r == LAST_IDX) begin
              // Index returns to 0 without touching cell 0 again.
              bit_idx_s = {IW{1'b0}};
`ifdef PARITY_CHECK_EN
              state_s   = PAR;
`else
              state_s   = DONE;
`endif
            end else begin
              bit_idx_s = bit_idx_r + IW'(1);
            end
          end else begin
            state_s = SHIFT;
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          ser_ready = 1'b1;
          if (ser_valid) begin
            if (ser_in != par_r) begin
              perr_s = 1'b1;
            end else begin
              perr_s = perr_r;
            end
            state_s = DONE;
          end else begin
            state_s = PAR;
          end
        end
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_s = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Bank drive is forced quiet while reset is asserted.
  assign load    = arst ? {WIDTH{1'b0}} : load_s;
  assign din     = arst ? 1'b0 : din_s;
  assign bit_idx = bit_idx_r;

  // FSM state and bit index registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r   <= IDLE;
      bit_idx_r <= {IW{1'b0}};
    end else begin
      state_r   <= state_s;
      bit_idx_r <= bit_idx_s;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity accumulator and sticky error flag.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      par_r  <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      par_r  <= par_s;
      perr_r <= perr_s;
    end
  end

  assign perr = perr_r;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_reg_load_ctrl.sv
// Directed self-checking bench for reg_load_ctrl (WIDTH=8). A behavioural
// register bank of DFlops is driven by load/din so bank contents can be
// compared with hand-computed values.
module tb_reg_load_ctrl;

`ifdef PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic       clk;
  logic       arst;
  logic       start;
  logic       abort;
  logic       clr;
  logic       ser_in;
  logic       ser_valid;
  logic       ser_ready;
  logic [7:0] load;
  logic       din;
  logic       busy;
  logic       done;
  logic       perr;
  logic [2:0] bit_idx;
  logic [7:0] bank;

  int checks;
  int failures;

  reg_load_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .arst      (arst),
    .start     (start),
    .abort     (abort),
    .clr       (clr),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .load      (load),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .perr      (perr),
    .bit_idx   (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bank of DFlop cells controlled by the DUT.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (load[k]) bank[k] <= din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; outputs settle by #1.
  task automatic drive(input logic s, input logic a, input logic c,
                       input logic v, input logic d);
    @(negedge clk);
    start = s; abort = a; clr = c; ser_valid = v; ser_in = d;
    #1;
  endtask

  // Full load of one word, optionally with a gap before every bit.
  task automatic load_word(input logic [7:0] data, input bit gaps,
                           input logic pbit, input logic pexp);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_idle_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap_load", load, 8'h00);
        chk("gap_idx", bit_idx, i[2:0]);
        chk("gap_ready", ser_ready, 1'b1);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, data[i]);
      chk("shift_load", load, 8'h01 << i);
      chk("shift_din", din, data[i]);
      chk("shift_idx", bit_idx, i[2:0]);
    end
    if (PEN) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, pbit);
      chk("par_load", load, 8'h00);
      chk("par_ready", ser_ready, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_pulse", done, 1'b1);
    chk("done_ready", ser_ready, 1'b0);
    chk("done_load", load, 8'h00);
    chk("done_busy", busy, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_done", done, 1'b0);
    chk("after_busy", busy, 1'b0);
    chk("bank", bank, data);
    chk("perr", perr, PEN & pexp);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    arst = 1'b1; start = 1'b0; abort = 1'b0; clr = 1'b1;
    ser_valid = 1'b1; ser_in = 1'b1;

    // Reset state, with clr and valid asserted to prove outputs are quiet.
    @(negedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ser_ready, 1'b0);
    chk("rst_load", load, 8'h00);
    chk("rst_din", din, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", bit_idx, 3'd0);
    chk("rst_perr", perr, 1'b0);
    @(negedge clk);
    arst = 1'b0; clr = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;

    // Continuous load of A5 (parity of A5 is 0).
    load_word(8'hA5, 1'b0, 1'b0, 1'b0);
    // Same load with a gap before every bit.
    load_word(8'hA5, 1'b1, 1'b0, 1'b0);
    // Wrong parity bit sets perr (parity builds), held until next start.
    load_word(8'h3C, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("perr_hold", perr, PEN);
    load_word(8'hFF, 1'b0, 1'b0, 1'b0);

    // Clear in IDLE.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_load", load, 8'hFF);
    chk("clr_din", din, 1'b0);
    chk("clr_busy", busy, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_bank", bank, 8'h00);

    // Abort on the 5th bit of 8'h05/1-in-bit4; clr/start in SHIFT ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("shift_clr_load", load, 8'h00);
    chk("shift_clr_idx", bit_idx, 3'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("after_ign_idx", bit_idx, 3'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("abort_load", load, 8'h00);
    chk("abort_ready", ser_ready, 1'b0);
    chk("abort_busy", busy, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_idle", busy, 1'b0);
    chk("abort_nodone", done, 1'b0);
    chk("abort_bank", bank, 8'h05);

    // Reset mid-SHIFT at bit_idx=3; start wins over clr in IDLE.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_over_clr", load, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_idx", bit_idx, 3'd3);
    arst = 1'b1; ser_valid = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_load", load, 8'h00);
    chk("mid_rst_idx", bit_idx, 3'd0);
    chk("mid_rst_ready", ser_ready, 1'b0);
    @(negedge clk);
    arst = 1'b0; ser_valid = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_done", done, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_done2", done, 1'b0);
    chk("post_rst_bank", bank, 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
